inst_loader: RTL

Writer side of the instruction memory that the fetch stage reads. Takes a byte stream from the UART receiver, frames it, and packs it into 32-bit instruction words. Writes those words sequentially into instruction memory from address 0. Holds the processor while loading, then releases it with a one-cycle PC-restart pulse.

---
 rtl/inst_loader_pkg.sv | 26 ++
 rtl/inst_loader_timer.sv | 44 ++++
 rtl/inst_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_pkg.sv
// Shared constants for the instruction loader: FSM state encodings, frame
// defaults and word/count geometry. The trailing-checksum option is selected
// with the INST_LOADER_CHECKSUM_EN macro.
package inst_loader_pkg;

  localparam int         BYTES_PER_WORD = 4;
  localparam int         CNT_W          = 16;
  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CNT_HI = 3'd1;
  localparam state_t ST_CNT_LO = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t ST_CHECK  = 3'd5;

  // Running XOR checksum over the data bytes of a frame.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

endpackage

// File: rtl/inst_loader_timer.sv
// Byte-gap timeout counter. Counts cycles since the last clear while enabled;
// expired is raised once the count reaches TIMEOUT_CYCLES. A TIMEOUT_CYCLES of
// 0 means the timer never expires.
module loader_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int         CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic       HAS_TO = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: cleared by a byte or while disabled, saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = HAS_TO && en && (cnt_q == LIMIT);

endmodule

// File: rtl/inst_loader.sv
// Instruction memory loader: frames a UART byte stream (sync, 16-bit word
// count, MSB-first words), writes the words from address 0, holds the CPU
// while loading and releases it with a PC-restart pulse on success.
// Optional trailing XOR checksum: define INST_LOADER_CHECKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int         ADDR_W         = 11,
  parameter int         DATA_W         = 32,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              pc_restart,
  output logic              load_done,
  output logic              load_error
);

  // Largest accepted word count: the full memory, 2^ADDR_W.
  localparam logic [CNT_W:0] MAX_CNT = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;
  localparam logic [1:0]     LAST_IDX = 2'(BYTES_PER_WORD - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              hold_q, hold_d;
  logic              restart_q, restart_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              timer_expired_s;
  logic [CNT_W-1:0]  cnt_val_s;
  logic              cnt_ok_s;
  logic              last_word_s;
  logic [DATA_W-1:0] word_next_s;

  loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clr    (rx_valid),
    .en     (state_q != ST_IDLE),
    .expired(timer_expired_s)
  );

  // Count as it will be once the low byte in rx_data is latched; range check.
  assign cnt_val_s   = {cnt_q[CNT_W-1:8], rx_data};
  assign cnt_ok_s    = (cnt_val_s != '0) && ({1'b0, cnt_val_s} <= MAX_CNT);
  // The word at addr_q is the last one when addr_q + 1 equals the count.
  assign last_word_s = ({{(CNT_W+1-ADDR_W){1'b0}}, addr_q} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, cnt_q};
  assign word_next_s = {word_q[DATA_W-9:0], rx_data};

  // Frame FSM and datapath next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    we_d        = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hold_d      = hold_q;
    restart_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_CNT_HI;
          hold_d  = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CNT_HI: begin
        if (rx_valid) begin
          cnt_d   = {rx_data, cnt_q[7:0]};
          state_d = ST_CNT_LO;
        end else if (timer_expired_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CNT_HI;
        end
      end
      ST_CNT_LO: begin
        if (rx_valid) begin
          cnt_d = cnt_val_s;
          if (cnt_ok_s) begin
            state_d    = ST_DATA;
            addr_d     = '0;
            byte_idx_d = 2'd0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_d     = 8'h00;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (timer_expired_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CNT_LO;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          word_d     = word_next_s;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d     = csum_update(csum_q, rx_data);
`endif
          if (byte_idx_q == LAST_IDX) begin
            we_d        = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = word_next_s;
            addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (last_word_s) begin
`ifdef INST_LOADER_CHECKSUM_EN
              state_d = ST_CHECK;
`else
              state_d = ST_DONE;
`endif
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else if (timer_expired_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (timer_expired_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif
      ST_DONE: begin
        done_d    = 1'b1;
        restart_d = 1'b1;
        hold_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and holds the CPU.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      byte_idx_q  <= 2'd0;
      word_q      <= '0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hold_q      <= 1'b1;
      restart_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hold_q      <= hold_d;
      restart_q   <= restart_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = hold_q;
  assign pc_restart = restart_q;
  assign load_done  = done_q;
  assign load_error = err_q;

endmodule
